// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud defaults and a compile-time divisor helper
package uart_pkg;
  localparam int OS_DEF = 16;
  localparam int DIV_DEF = 27;
  function automatic int calc_div(longint clk_hz, longint baud, longint os);
    return int'((clk_hz + baud * os / 2) / (baud * os));
  endfunction
endpackage

// File: rtl/baud_prescaler.sv
// baud_prescaler: divide-by-eff counter emitting a terminal-count pulse
module baud_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] eff_i,
  output logic             tc_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  // >= keeps the count bounded if eff shrinks while the counter is paused
  assign tc_o = en_i && (cnt_q >= eff_i - 1'b1);
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/baud_gen.sv
// baud_gen: programmable baud generator with oversample, mid-bit and bit ticks
module baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = OS_DEF,
  parameter int DEFAULT_DIV = DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             div_load_i,
  input  logic [DIV_W-1:0] div_in_i,
  input  logic             sync_clr_i,
  output logic             tick_os_o,
  output logic             tick_mid_o,
  output logic             tick_bit_o,
  output logic             baud_clk_o,
  output logic [DIV_W-1:0] div_cur_o
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_END  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2);
  logic [OW-1:0]    os_q, os_d;
  logic [DIV_W-1:0] div_q, div_d, sh_q, sh_d, eff;
  logic             pend_q, pend_d, tos_q, tos_d, tmid_q, tmid_d, tbit_q, tbit_d;
  logic             bclk_q, bclk_d, tc, apply;
  assign eff = (div_q == '0) ? DIV_W'(1) : div_q;
  baud_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en_i),
    .clr_i (sync_clr_i),
    .eff_i (eff),
    .tc_o  (tc)
  );
  // a new divisor only takes effect on a bit boundary, a resync, or while paused
  always_comb begin
    tos_d  = tc && !sync_clr_i;
    tmid_d = tos_d && (os_q == OS_MID);
    tbit_d = tos_d && (os_q == OS_END);
    os_d   = sync_clr_i ? '0 : tc ? ((os_q == OS_END) ? '0 : os_q + 1'b1) : os_q;
    bclk_d = os_d >= OS_HALF;
    apply  = pend_q && (sync_clr_i || !en_i || tbit_d);
    div_d  = apply ? sh_q : div_q;
    sh_d   = div_load_i ? div_in_i : sh_q;
    pend_d = div_load_i || (pend_q && !apply);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      os_q   <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      sh_q   <= '0;
      pend_q <= 1'b0;
      tos_q  <= 1'b0;
      tmid_q <= 1'b0;
      tbit_q <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      os_q   <= os_d;
      div_q  <= div_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      tos_q  <= tos_d;
      tmid_q <= tmid_d;
      tbit_q <= tbit_d;
      bclk_q <= bclk_d;
    end
  assign tick_os_o  = tos_q;
  assign tick_mid_o = tmid_q;
  assign tick_bit_o = tbit_q;
  assign baud_clk_o = bclk_q;
  assign div_cur_o  = div_q;
endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: directed and randomized checks of baud_gen against a bit-position model
module tb_baud_gen;
  localparam int OS = 16;
  localparam int DW = 16;
  localparam int DD = 4;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, ld = 1'b0, sc = 1'b0;
  logic [DW-1:0] din = '0;
  logic tick_os, tick_mid, tick_bit, baud_clk;
  logic [DW-1:0] div_cur;
  int checks = 0, errors = 0;
  int p;
  logic [DW-1:0] m_div, m_sh;
  bit m_pend, m_tos, m_tmid, m_tbit, m_bclk;

  baud_gen #(.DIV_W(DW), .OVERSAMPLE(OS), .DEFAULT_DIV(DD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .div_load_i (ld),
    .div_in_i   (din),
    .sync_clr_i (sc),
    .tick_os_o  (tick_os),
    .tick_mid_o (tick_mid),
    .tick_bit_o (tick_bit),
    .baud_clk_o (baud_clk),
    .div_cur_o  (div_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = 0; m_div = DW'(DD); m_sh = '0; m_pend = 0;
    m_tos = 0; m_tmid = 0; m_tbit = 0; m_bclk = 0;
  endtask

  // p = enabled cycles elapsed inside the current bit period of eff*OS cycles
  task automatic model_edge();
    int e, per;
    bit apply;
    e = (m_div == 0) ? 1 : int'(m_div);
    per = e * OS;
    m_tos = 0; m_tmid = 0; m_tbit = 0; apply = 0;
    if (sc) begin
      p = 0; m_bclk = 0; apply = m_pend;
    end else if (en) begin
      p++;
      m_tos  = (p % e) == 0;
      m_tmid = m_tos && (p == per / 2);
      m_tbit = (p == per);
      if (m_tbit) p = 0;
      m_bclk = p >= per / 2;
      apply  = m_pend && m_tbit;
    end else apply = m_pend;
    if (apply) m_div = m_sh;
    m_pend = ld || (m_pend && !apply);
    if (ld) m_sh = din;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".tick_os"}, 32'(tick_os), 32'(m_tos));
    chk({tag, ".tick_mid"}, 32'(tick_mid), 32'(m_tmid));
    chk({tag, ".tick_bit"}, 32'(tick_bit), 32'(m_tbit));
    chk({tag, ".baud_clk"}, 32'(baud_clk), 32'(m_bclk));
    chk({tag, ".div_cur"}, 32'(div_cur), 32'(m_div));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ticks"}, {29'd0, tick_os, tick_mid, tick_bit}, 32'd0);
    chk({tag, ".baud_clk"}, 32'(baud_clk), 32'd0);
    chk({tag, ".div_cur"}, 32'(div_cur), 32'(DD));
  endtask

  initial begin
    int first_mid, first_bit, n_os, n_bit, k;
    logic held;
    // reset and free-running default divisor
    #2 rst_n = 1'b0;
    #10 check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    first_mid = -1; n_os = 0; n_bit = 0;
    for (int i = 1; i <= 200; i++) begin
      step("run");
      if (tick_mid && first_mid < 0) first_mid = i;
      n_os += int'(tick_os); n_bit += int'(tick_bit);
    end
    chk("first_mid", 32'(first_mid), 32'd32);
    chk("os_count", 32'(n_os), 32'd50);
    chk("bit_count", 32'(n_bit), 32'd3);
    // divisor change mid-bit applies at the bit boundary
    for (int i = 0; i < 100 && p != 20; i++) step("seek5");
    chk("seek5", 32'(p), 32'd20);
    ld = 1'b1; din = 16'd2;
    step("load2");
    ld = 1'b0;
    k = 0;
    for (int i = 0; i < 150; i++) begin
      step("div2");
      if (tick_bit && k == 0) begin
        chk("apply_at_bit", 32'(div_cur), 32'd2);
        k = 1;
      end
    end
    chk("apply_seen", 32'(k), 32'd1);
    // divisor 0 and 1 loaded while paused
    for (int v = 0; v < 2; v++) begin
      en = 1'b0; ld = 1'b1; din = DW'(v);
      step("pload");
      ld = 1'b0;
      step("papply");
      chk("paused_div", 32'(div_cur), 32'(v));
      sc = 1'b1;
      step("psync");
      sc = 1'b0; en = 1'b1;
      n_os = 0; n_bit = 0;
      for (int i = 0; i < 40; i++) begin
        step("eff1");
        n_os += int'(tick_os); n_bit += int'(tick_bit);
      end
      chk("eff1_os", 32'(n_os), 32'd40);
      chk("eff1_bit", 32'(n_bit), 32'd2);
    end
    // back to divisor 4, then resync at os_cnt=11 on a terminal count
    ld = 1'b1; din = 16'd4;
    step("load4");
    ld = 1'b0;
    for (int i = 0; i < 100 && (m_pend || m_div != 4); i++) step("wait4");
    for (int i = 0; i < 100 && p != 47; i++) step("seek11");
    chk("seek11", 32'(p), 32'd47);
    sc = 1'b1;
    step("sync");
    sc = 1'b0;
    chk("sync_notick", 32'(tick_os), 32'd0);
    chk("sync_baud", 32'(baud_clk), 32'd0);
    first_mid = -1; first_bit = -1;
    for (int i = 1; i <= 64; i++) begin
      step("postsync");
      if (tick_mid && first_mid < 0) first_mid = i;
      if (tick_bit && first_bit < 0) first_bit = i;
    end
    chk("sync_mid", 32'(first_mid), 32'd32);
    chk("sync_bit", 32'(first_bit), 32'd64);
    // pause at pre_cnt=2
    for (int i = 0; i < 10 && (p % 4) != 2; i++) step("seekpre2");
    chk("seekpre2", 32'(p % 4), 32'd2);
    held = baud_clk;
    en = 1'b0;
    n_os = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      step("pause");
      n_os += int'(tick_os | tick_mid | tick_bit);
      k += int'(baud_clk !== held);
    end
    chk("pause_ticks", 32'(n_os), 32'd0);
    chk("pause_baud", 32'(k), 32'd0);
    en = 1'b1;
    k = -1;
    for (int i = 1; i <= 10 && k < 0; i++) begin
      step("resume");
      if (tick_os) k = i;
    end
    chk("resume_os", 32'(k), 32'd2);
    // randomized traffic; enable stays high while a load is pending
    for (int i = 0; i < 1500; i++) begin
      en = m_pend ? 1'b1 : ($urandom_range(7) != 0);
      ld = en && ($urandom_range(39) == 0);
      din = DW'($urandom_range(5));
      sc = ($urandom_range(99) == 0);
      step("rand");
    end
    ld = 1'b0; sc = 1'b0; en = 1'b1;
    // async reset with a pending load
    for (int i = 0; i < 40 && (m_pend || p != 20); i++) step("seekrst");
    ld = 1'b1; din = 16'd2;
    step("rstload");
    ld = 1'b0;
    step("rstpend");
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 140; i++) step("postrst");
    chk("pending_dropped", 32'(div_cur), 32'(DD));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
